// File: rtl/s3_writeback.sv
// s3_writeback: stage 3 (memory/writeback) of the 3-stage RV32I pipeline.
// Registers stage-2 results, selects register-file writeback data (ALU,
// PC+4 or aligned load data) and owns the tohost CSR.
// Optional feature: define S3_PERF_COUNTERS_EN to build the cycle/instret
// counters; without it both counter ports are tied to zero.
module s3_writeback #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN   = 32'h0000_0013,
  parameter logic [11:0] TOHOST_ADR = 12'h51E
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] instruction_s2,
  input  logic [31:0] pc_s2,
  input  logic [31:0] alu_out_s2,
  input  logic [31:0] rs1_data_s2,
  input  logic        csr_we,
  input  logic [31:0] dmem_dout,
  output logic [31:0] instruction_s3,
  output logic        valid_s3,
  output logic [4:0]  rd_s3,
  output logic        rf_we,
  output logic [31:0] wb_data,
  output logic [31:0] csr_tohost,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
);

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;

  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] tohost_q, tohost_d;

  // Next-state for the pipeline registers and tohost: flush beats stall, stall holds everything.
  always_comb begin
    instr_d  = instr_q;
    valid_d  = valid_q;
    pc_d     = pc_q;
    alu_d    = alu_q;
    tohost_d = tohost_q;
    if (flush) begin
      instr_d = NOP_INSN;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = instruction_s2;
      valid_d = 1'b1;
      pc_d    = pc_s2;
      alu_d   = alu_out_s2;
      if (csr_we && (instruction_s2[31:20] == TOHOST_ADR)) begin
        case (instruction_s2[14:12])
          3'b001:  tohost_d = rs1_data_s2;
          3'b101:  tohost_d = {27'b0, instruction_s2[19:15]};
          default: tohost_d = tohost_q;
        endcase
      end
    end
  end

  // Pipeline register bank with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q  <= NOP_INSN;
      valid_q  <= 1'b0;
      pc_q     <= RESET_PC;
      alu_q    <= 32'h0;
      tohost_q <= 32'h0;
    end else begin
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      alu_q    <= alu_d;
      tohost_q <= tohost_d;
    end
  end

  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic        writes_rd;

  // Writeback data and register-file enable, purely from stage-3 state and DMEM data.
  always_comb begin
    opcode    = instr_q[6:0];
    func3     = instr_q[14:12];
    load_byte = 8'h0;
    load_half = alu_q[1] ? dmem_dout[31:16] : dmem_dout[15:0];
    case (alu_q[1:0])
      2'd0:    load_byte = dmem_dout[7:0];
      2'd1:    load_byte = dmem_dout[15:8];
      2'd2:    load_byte = dmem_dout[23:16];
      default: load_byte = dmem_dout[31:24];
    endcase
    case (func3)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'b0, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'b0, load_half};
      3'b010:  load_data = dmem_dout;
      default: load_data = 32'h0;
    endcase
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_LOAD, OPC_ARI_RTYPE, OPC_ARI_ITYPE: writes_rd = 1'b1;
      default:                                writes_rd = 1'b0;
    endcase
    if ((opcode == OPC_JAL) || (opcode == OPC_JALR)) begin
      wb_data = pc_q + 32'd4;
    end else if (opcode == OPC_LOAD) begin
      wb_data = load_data;
    end else begin
      wb_data = alu_q;
    end
    rf_we = valid_q && (instr_q[11:7] != 5'd0) && writes_rd;
  end

  assign instruction_s3 = instr_q;
  assign valid_s3       = valid_q;
  assign rd_s3          = instr_q[11:7];
  assign csr_tohost     = tohost_q;

`ifdef S3_PERF_COUNTERS_EN
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] instret_q, instret_d;

  // Cycle counter runs every edge; instret counts a valid instruction leaving stage 3.
  always_comb begin
    cycle_d   = cycle_q + 32'd1;
    instret_d = (valid_q && !stall) ? instret_q + 32'd1 : instret_q;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= 32'h0;
      instret_q <= 32'h0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
`else
  assign cycle_count   = 32'h0;
  assign instret_count = 32'h0;
`endif

endmodule

// File: tb/tb_s3_writeback.sv
// tb_s3_writeback: directed vectors for s3_writeback. The driver pushes the
// hand-computed stage-3 state expected after each edge; a monitor pops and
// compares it on the following falling edge.
module tb_s3_writeback;

`ifdef S3_PERF_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] instruction_s2;
  logic [31:0] pc_s2;
  logic [31:0] alu_out_s2;
  logic [31:0] rs1_data_s2;
  logic        csr_we;
  logic [31:0] dmem_dout;
  logic [31:0] instruction_s3;
  logic        valid_s3;
  logic [4:0]  rd_s3;
  logic        rf_we;
  logic [31:0] wb_data;
  logic [31:0] csr_tohost;
  logic [31:0] cycle_count;
  logic [31:0] instret_count;

  typedef struct {
    int          id;
    logic [31:0] instr;
    logic        valid;
    logic        rf_we;
    logic [4:0]  rd;
    logic [31:0] wb;
    logic        chk_wb;
    logic [31:0] tohost;
    logic        chk_cnt;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  s3_writeback dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .instruction_s2 (instruction_s2),
    .pc_s2          (pc_s2),
    .alu_out_s2     (alu_out_s2),
    .rs1_data_s2    (rs1_data_s2),
    .csr_we         (csr_we),
    .dmem_dout      (dmem_dout),
    .instruction_s3 (instruction_s3),
    .valid_s3       (valid_s3),
    .rd_s3          (rd_s3),
    .rf_we          (rf_we),
    .wb_data        (wb_data),
    .csr_tohost     (csr_tohost),
    .cycle_count    (cycle_count),
    .instret_count  (instret_count)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s vec=%0d actual=%h required=%h", name, id, act, req);
    end
  endtask

  // Drive one vector just after a falling edge and queue the state expected after the next rising edge.
  task automatic applyStimulus(input int id, input logic r, input logic s, input logic f,
                               input logic [31:0] insn, input logic [31:0] pc, input logic [31:0] alu,
                               input logic [31:0] rs1, input logic cwe,
                               input logic [31:0] e_instr, input logic e_valid, input logic e_rfwe,
                               input logic [4:0] e_rd, input logic [31:0] e_wb, input logic e_chkwb,
                               input logic [31:0] e_tohost, input logic e_chkcnt,
                               input logic [31:0] e_cyc, input logic [31:0] e_ret);
    exp_t e;
    @(negedge clk);
    #1;
    rst            = r;
    stall          = s;
    flush          = f;
    instruction_s2 = insn;
    pc_s2          = pc;
    alu_out_s2     = alu;
    rs1_data_s2    = rs1;
    csr_we         = cwe;
    e.id      = id;
    e.instr   = e_instr;
    e.valid   = e_valid;
    e.rf_we   = e_rfwe;
    e.rd      = e_rd;
    e.wb      = e_wb;
    e.chk_wb  = e_chkwb;
    e.tohost  = e_tohost;
    e.chk_cnt = e_chkcnt;
    e.cyc     = CNT_EN ? e_cyc : 32'h0;
    e.ret     = CNT_EN ? e_ret : 32'h0;
    exp_q.push_back(e);
  endtask

  // Monitor: every falling edge with a pending expectation, compare the stage-3 outputs.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput("instruction_s3", e.id, instruction_s3, e.instr);
      checkOutput("valid_s3", e.id, {31'b0, valid_s3}, {31'b0, e.valid});
      checkOutput("rf_we", e.id, {31'b0, rf_we}, {31'b0, e.rf_we});
      checkOutput("rd_s3", e.id, {27'b0, rd_s3}, {27'b0, e.rd});
      checkOutput("csr_tohost", e.id, csr_tohost, e.tohost);
      if (e.chk_wb) checkOutput("wb_data", e.id, wb_data, e.wb);
      if (e.chk_cnt) begin
        checkOutput("cycle_count", e.id, cycle_count, e.cyc);
        checkOutput("instret_count", e.id, instret_count, e.ret);
      end
    end
  end

  // Directed stimulus sequence followed by a bounded drain of the scoreboard.
  initial begin
    int drain;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; instruction_s2 = 32'h0000_0013;
    pc_s2 = 32'h0; alu_out_s2 = 32'h0; rs1_data_s2 = 32'h0; csr_we = 1'b0;
    dmem_dout = 32'h8899_AABB;

    // reset
    applyStimulus(1, 1,0,0, 32'h0070_0293, 32'h0, 32'h7, 32'h0, 0, 32'h0000_0013,0,0,5'd0,32'h0,1, 32'h0,1,32'd0,32'd0);
    applyStimulus(2, 1,0,0, 32'h0070_0293, 32'h0, 32'h7, 32'h0, 0, 32'h0000_0013,0,0,5'd0,32'h0,1, 32'h0,1,32'd0,32'd0);
    // ALU / jump writeback
    applyStimulus(3, 0,0,0, 32'h0070_0293, 32'h0, 32'h7, 32'h0, 0, 32'h0070_0293,1,1,5'd5,32'h7,1, 32'h0,1,32'd1,32'd0);
    applyStimulus(4, 0,0,0, 32'h0070_0013, 32'h4, 32'h7, 32'h0, 0, 32'h0070_0013,1,0,5'd0,32'h7,1, 32'h0,1,32'd2,32'd1);
    applyStimulus(5, 0,0,0, 32'h0000_00EF, 32'h0000_1000, 32'h1234_5678, 32'h0, 0, 32'h0000_00EF,1,1,5'd1,32'h0000_1004,1, 32'h0,1,32'd3,32'd2);
    applyStimulus(6, 0,0,0, 32'h0000_00EF, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0, 0, 32'h0000_00EF,1,1,5'd1,32'h0,1, 32'h0,1,32'd4,32'd3);
    // loads with dmem_dout = 8899_AABB
    applyStimulus(7, 0,0,0, 32'h0000_0303, 32'h0, 32'h101, 32'h0, 0, 32'h0000_0303,1,1,5'd6,32'hFFFF_FFAA,1, 32'h0,1,32'd5,32'd4);
    applyStimulus(8, 0,0,0, 32'h0000_4303, 32'h0, 32'h103, 32'h0, 0, 32'h0000_4303,1,1,5'd6,32'h0000_0088,1, 32'h0,1,32'd6,32'd5);
    applyStimulus(9, 0,0,0, 32'h0000_1303, 32'h0, 32'h102, 32'h0, 0, 32'h0000_1303,1,1,5'd6,32'hFFFF_8899,1, 32'h0,1,32'd7,32'd6);
    applyStimulus(10, 0,0,0, 32'h0000_5303, 32'h0, 32'h100, 32'h0, 0, 32'h0000_5303,1,1,5'd6,32'h0000_AABB,1, 32'h0,1,32'd8,32'd7);
    applyStimulus(11, 0,0,0, 32'h0000_2303, 32'h0, 32'h103, 32'h0, 0, 32'h0000_2303,1,1,5'd6,32'h8899_AABB,1, 32'h0,1,32'd9,32'd8);
    applyStimulus(12, 0,0,0, 32'h0000_3303, 32'h0, 32'h100, 32'h0, 0, 32'h0000_3303,1,1,5'd6,32'h0,1, 32'h0,1,32'd10,32'd9);
    // store and branch never write the register file
    applyStimulus(13, 0,0,0, 32'h0000_0323, 32'h0, 32'h40, 32'h0, 0, 32'h0000_0323,1,0,5'd6,32'h40,1, 32'h0,1,32'd11,32'd10);
    applyStimulus(14, 0,0,0, 32'h0000_03E3, 32'h0, 32'h55, 32'h0, 0, 32'h0000_03E3,1,0,5'd7,32'h55,1, 32'h0,1,32'd12,32'd11);
    // tohost CSR writes
    applyStimulus(20, 0,0,0, 32'h51E0_9073, 32'h0, 32'h0, 32'hDEAD_BEEF, 1, 32'h51E0_9073,1,0,5'd0,32'h0,1, 32'hDEAD_BEEF,0,32'd0,32'd0);
    applyStimulus(21, 0,0,0, 32'h51E2_D073, 32'h0, 32'h0, 32'hDEAD_BEEF, 1, 32'h51E2_D073,1,0,5'd0,32'h0,1, 32'h0000_0005,0,32'd0,32'd0);
    applyStimulus(22, 0,1,0, 32'h51E0_9073, 32'h0, 32'h0, 32'h1111_1111, 1, 32'h51E2_D073,1,0,5'd0,32'h0,1, 32'h0000_0005,0,32'd0,32'd0);
    applyStimulus(23, 0,0,1, 32'h51E0_9073, 32'h0, 32'h0, 32'h2222_2222, 1, 32'h0000_0013,0,0,5'd0,32'h0,0, 32'h0000_0005,0,32'd0,32'd0);
    applyStimulus(24, 0,0,0, 32'h51F0_9073, 32'h0, 32'h0, 32'h3333_3333, 1, 32'h51F0_9073,1,0,5'd0,32'h0,1, 32'h0000_0005,0,32'd0,32'd0);
    applyStimulus(25, 0,0,0, 32'h51E0_A073, 32'h0, 32'h0, 32'h4444_4444, 1, 32'h51E0_A073,1,0,5'd0,32'h0,1, 32'h0000_0005,0,32'd0,32'd0);
    applyStimulus(26, 0,0,0, 32'h51E0_9073, 32'h0, 32'h0, 32'h5555_5555, 0, 32'h51E0_9073,1,0,5'd0,32'h0,1, 32'h0000_0005,0,32'd0,32'd0);
    applyStimulus(27, 0,0,0, 32'h0000_01B7, 32'h0, 32'hABCD_E000, 32'h0, 0, 32'h0000_01B7,1,1,5'd3,32'hABCD_E000,1, 32'h0000_0005,0,32'd0,32'd0);
    // fresh reset, then stall 3 cycles and flush with a load waiting in stage 2
    applyStimulus(30, 1,0,0, 32'h0000_2303, 32'h0, 32'h100, 32'h0, 0, 32'h0000_0013,0,0,5'd0,32'h0,1, 32'h0,1,32'd0,32'd0);
    applyStimulus(31, 0,0,0, 32'h0000_2303, 32'h0, 32'h100, 32'h0, 0, 32'h0000_2303,1,1,5'd6,32'h8899_AABB,1, 32'h0,1,32'd1,32'd0);
    applyStimulus(32, 0,1,0, 32'h0000_0303, 32'h0, 32'h101, 32'h0, 0, 32'h0000_2303,1,1,5'd6,32'h8899_AABB,1, 32'h0,1,32'd2,32'd0);
    applyStimulus(33, 0,1,0, 32'h0000_0303, 32'h0, 32'h101, 32'h0, 0, 32'h0000_2303,1,1,5'd6,32'h8899_AABB,1, 32'h0,1,32'd3,32'd0);
    applyStimulus(34, 0,1,0, 32'h0000_0303, 32'h0, 32'h101, 32'h0, 0, 32'h0000_2303,1,1,5'd6,32'h8899_AABB,1, 32'h0,1,32'd4,32'd0);
    applyStimulus(35, 0,1,1, 32'h0000_0303, 32'h0, 32'h101, 32'h0, 0, 32'h0000_0013,0,0,5'd0,32'h0,0, 32'h0,1,32'd5,32'd0);
    applyStimulus(36, 0,0,0, 32'h0070_0293, 32'h0, 32'h7, 32'h0, 0, 32'h0070_0293,1,1,5'd5,32'h7,1, 32'h0,1,32'd6,32'd0);
    applyStimulus(37, 0,0,0, 32'h0070_0013, 32'h0, 32'h7, 32'h0, 0, 32'h0070_0013,1,0,5'd0,32'h7,1, 32'h0,1,32'd7,32'd1);

    drain = 0;
    while ((exp_q.size() != 0) && (drain < 10)) begin
      @(negedge clk);
      drain++;
    end
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d pending required=0 pending", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
